cve2_obi_mux: RTL

//  Parametrised OBI manager-side multiplexer: merges NUM_CH core bus ports (e.g. cve2 instr + data,
//  or several harts) onto one OBI subordinate port. Round-robin arbitration, in-order response

---
 rtl/cve2_obi_mux.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cve2_obi_mux.sv
// cve2_obi_mux: round-robin N:1 OBI request mux with in-order response routing; optional response timeout enabled by CVE2_OBI_MUX_TIMEOUT_EN
module cve2_obi_mux #(
  parameter int NUM_CH          = 2,
  parameter int MAX_OUTSTANDING = 2
`ifdef CVE2_OBI_MUX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      m_req_i,
  output logic [NUM_CH-1:0]      m_gnt_o,
  input  logic [NUM_CH-1:0]      m_we_i,
  input  logic [4*NUM_CH-1:0]    m_be_i,
  input  logic [32*NUM_CH-1:0]   m_addr_i,
  input  logic [32*NUM_CH-1:0]   m_wdata_i,
  output logic [NUM_CH-1:0]      m_rvalid_o,
  output logic [31:0]            m_rdata_o,
  output logic [NUM_CH-1:0]      m_err_o,
  output logic                   s_req_o,
  input  logic                   s_gnt_i,
  output logic                   s_we_o,
  output logic [3:0]             s_be_o,
  output logic [31:0]            s_addr_o,
  output logic [31:0]            s_wdata_o,
  input  logic                   s_rvalid_i,
  input  logic [31:0]            s_rdata_i,
  input  logic                   s_err_i,
`ifdef CVE2_OBI_MUX_TIMEOUT_EN
  output logic                   timeout_o,
`endif
  output logic                   busy_o,
  output logic                   stray_rsp_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int KW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] rr, lock_ch, arb, idx, sel, head;
  logic          locked, found, nonempty, full, req, grant, pop, rerr;
  logic [CW-1:0] mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [KW-1:0] cnt;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  // first requesting channel at or after the round-robin pointer, wrapping
  always_comb begin
    arb   = rr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CW'((int'(rr) + i) % NUM_CH);
      if (!found && m_req_i[idx]) begin
        arb   = idx;
        found = 1'b1;
      end
    end
  end
  // a request left waiting for grant keeps its channel so the bus request stays stable
  assign sel      = locked ? lock_ch : arb;
  assign head     = mem[rd_ptr];
  assign nonempty = cnt != '0;
  assign full     = cnt == KW'(MAX_OUTSTANDING);
  assign req      = |m_req_i && !full && !rst_i;
  assign grant    = req && s_gnt_i;
`ifdef CVE2_OBI_MUX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    disc;
  logic          drop, tmo_hit, timeout_q;
  // late responses to timed-out transactions are swallowed before reaching the fifo head
  assign drop        = s_rvalid_i && disc != '0;
  assign tmo_hit     = nonempty && !s_rvalid_i && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign pop         = (s_rvalid_i && !drop && nonempty) || tmo_hit;
  assign rerr        = tmo_hit || s_err_i;
  assign stray_rsp_o = !rst_i && s_rvalid_i && !drop && !nonempty;
  assign timeout_o   = !rst_i && timeout_q;
  // wait counter for the head transaction, discard count and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      disc      <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt   <= (!nonempty || s_rvalid_i || tmo_hit) ? '0 : tmo_cnt + 1'b1;
      disc      <= disc + 8'(tmo_hit) - 8'(drop);
      timeout_q <= timeout_q || tmo_hit;
    end
  end
`else
  assign pop         = s_rvalid_i && nonempty;
  assign rerr        = s_err_i;
  assign stray_rsp_o = !rst_i && s_rvalid_i && !nonempty;
`endif
  assign m_gnt_o    = grant ? NUM_CH'(1) << sel : '0;
  assign m_rvalid_o = (pop && !rst_i) ? NUM_CH'(1) << head : '0;
  assign m_err_o    = (pop && rerr && !rst_i) ? NUM_CH'(1) << head : '0;
  assign m_rdata_o  = s_rdata_i;
  assign s_req_o    = req;
  assign s_we_o     = !rst_i && m_we_i[sel];
  assign s_be_o     = rst_i ? '0 : m_be_i[4*sel +: 4];
  assign s_addr_o   = rst_i ? '0 : m_addr_i[32*sel +: 32];
  assign s_wdata_o  = rst_i ? '0 : m_wdata_i[32*sel +: 32];
  assign busy_o     = !rst_i && nonempty;
  // arbitration state and the channel-id fifo that routes responses in order
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr      <= '0;
      locked  <= 1'b0;
      lock_ch <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (grant) begin
        mem[wr_ptr] <= sel;
        wr_ptr      <= inc(wr_ptr);
        rr          <= (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        locked      <= 1'b0;
      end else if (req) begin
        locked  <= 1'b1;
        lock_ch <= sel;
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + KW'(grant) - KW'(pop);
    end
  end
endmodule
